// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared widths, types and defaults for the PPU VRAM arbiter
package ppu_pkg;

    localparam int ADDR_W               = 14;
    localparam int DATA_W               = 8;
    localparam int STARVE_LIMIT_DEFAULT = 8;

    typedef enum logic [1:0] {
        CPU_IDLE   = 2'd0,
        CPU_PEND   = 2'd1,
        CPU_FLIGHT = 2'd2
    } cpu_state_t;

    typedef enum logic {
        OWN_RND = 1'b0,
        OWN_CPU = 1'b1
    } owner_t;

endpackage

// File: rtl/ppu_rd_tag_pipe.sv
// rtl/ppu_rd_tag_pipe.sv - two-stage valid/owner tag shift register for read returns
module ppu_rd_tag_pipe
    import ppu_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    input  owner_t in_owner,
    output logic   out_valid,
    output owner_t out_owner
);

    logic   s1_valid;
    owner_t s1_owner;

    // Stage 1 lines up with the issue cycle, stage 2 with the cycle data_in is valid
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_owner  <= OWN_RND;
            out_valid <= 1'b0;
            out_owner <= OWN_RND;
        end else begin
            s1_valid  <= in_valid;
            s1_owner  <= in_owner;
            out_valid <= s1_valid;
            out_owner <= s1_owner;
        end
    end

endmodule

// File: rtl/ppu_vram_arbiter.sv
// rtl/ppu_vram_arbiter.sv - VRAM port arbiter between render fetches and CPU PPUDATA accesses
module ppu_vram_arbiter
    import ppu_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rnd_req,
    input  logic [ADDR_W-1:0] rnd_addr,
    output logic              rnd_ack,
    output logic              rnd_rvalid,
    output logic [DATA_W-1:0] rnd_rdata,
    input  logic              cpu_req,
    input  logic              cpu_r_nw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] addr,
    output logic              write_request,
    output logic              read_request
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    cpu_state_t        state;
    logic [CNT_W-1:0]  starve_cnt;
    logic              slot_r_nw;
    logic [ADDR_W-1:0] slot_addr;
    logic [DATA_W-1:0] slot_wdata;

    logic              grant_rnd;
    logic              grant_cpu;
    logic              tag_valid;
    owner_t            tag_owner;
    owner_t            issue_owner;
    logic              cpu_return;

    // Render wins unless the waiting CPU access has already been passed over STARVE_LIMIT times
    assign grant_rnd   = rnd_req && (starve_cnt < CNT_W'(STARVE_LIMIT));
    assign grant_cpu   = !grant_rnd && (state == CPU_PEND);
    assign rnd_ack     = grant_rnd;
    assign issue_owner = grant_cpu ? OWN_CPU : OWN_RND;
    assign cpu_return  = tag_valid && (tag_owner == OWN_CPU);

    ppu_rd_tag_pipe u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (grant_rnd || (grant_cpu && slot_r_nw)),
        .in_owner  (issue_owner),
        .out_valid (tag_valid),
        .out_owner (tag_owner)
    );

    // CPU slot controller: capture, wait for a grant, then wait for the read to return
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CPU_IDLE;
            cpu_busy   <= 1'b0;
            starve_cnt <= '0;
            slot_r_nw  <= 1'b0;
            slot_addr  <= '0;
            slot_wdata <= '0;
        end else begin
            // grant_rnd already requires starve_cnt < STARVE_LIMIT, so this saturates there
            if ((state == CPU_PEND) && grant_rnd) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end else begin
                starve_cnt <= '0;
            end

            case (state)
                CPU_IDLE: begin
                    if (cpu_req) begin
                        slot_r_nw  <= cpu_r_nw;
                        slot_addr  <= cpu_addr;
                        slot_wdata <= cpu_wdata;
                        cpu_busy   <= 1'b1;
                        state      <= CPU_PEND;
                    end
                end
                CPU_PEND: begin
                    if (grant_cpu) begin
                        // A write completes in its issue cycle, so it never lingers in FLIGHT
                        if (slot_r_nw) begin
                            state <= CPU_FLIGHT;
                        end else begin
                            cpu_busy <= 1'b0;
                            state    <= CPU_IDLE;
                        end
                    end
                end
                CPU_FLIGHT: begin
                    if (cpu_return) begin
                        cpu_busy <= 1'b0;
                        state    <= CPU_IDLE;
                    end
                end
                default: begin
                    cpu_busy <= 1'b0;
                    state    <= CPU_IDLE;
                end
            endcase
        end
    end

    // Memory issue stage and read-return steering by tag owner
    always_ff @(posedge clk) begin
        if (rst) begin
            read_request  <= 1'b0;
            write_request <= 1'b0;
            addr          <= '0;
            data_out      <= '0;
            rnd_rvalid    <= 1'b0;
            rnd_rdata     <= '0;
            cpu_done      <= 1'b0;
            cpu_rdata     <= '0;
        end else begin
            read_request  <= 1'b0;
            write_request <= 1'b0;
            rnd_rvalid    <= 1'b0;
            cpu_done      <= (grant_cpu && !slot_r_nw) || cpu_return;

            if (grant_rnd) begin
                addr         <= rnd_addr;
                read_request <= 1'b1;
            end else if (grant_cpu) begin
                addr <= slot_addr;
                if (slot_r_nw) begin
                    read_request <= 1'b1;
                end else begin
                    write_request <= 1'b1;
                    data_out      <= slot_wdata;
                end
            end

            if (tag_valid) begin
                if (tag_owner == OWN_CPU) begin
                    cpu_rdata <= data_in;
                end else begin
                    rnd_rvalid <= 1'b1;
                    rnd_rdata  <= data_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// tb/tb_ppu_vram_arbiter.sv - scoreboard bench for ppu_vram_arbiter
module tb_ppu_vram_arbiter;

    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rnd_req = 1'b0;
    logic [13:0] rnd_addr = '0;
    logic        rnd_ack;
    logic        rnd_rvalid;
    logic [7:0]  rnd_rdata;
    logic        cpu_req = 1'b0;
    logic        cpu_r_nw = 1'b0;
    logic [13:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_busy;
    logic        cpu_done;
    logic [7:0]  cpu_rdata;
    logic [7:0]  data_in = '0;
    logic [7:0]  data_out;
    logic [13:0] addr;
    logic        write_request;
    logic        read_request;

    always #20 clk = ~clk;

    ppu_vram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk           (clk),
        .rst           (rst),
        .rnd_req       (rnd_req),
        .rnd_addr      (rnd_addr),
        .rnd_ack       (rnd_ack),
        .rnd_rvalid    (rnd_rvalid),
        .rnd_rdata     (rnd_rdata),
        .cpu_req       (cpu_req),
        .cpu_r_nw      (cpu_r_nw),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_busy      (cpu_busy),
        .cpu_done      (cpu_done),
        .cpu_rdata     (cpu_rdata),
        .data_in       (data_in),
        .data_out      (data_out),
        .addr          (addr),
        .write_request (write_request),
        .read_request  (read_request)
    );

    typedef struct {
        int          due;
        logic [13:0] a;
        logic [7:0]  d;
        bit          is_rd;
    } exp_t;

    exp_t q_rd[$];
    exp_t q_wr[$];
    exp_t q_rv[$];
    exp_t q_cd[$];

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  armed = 1'b0;
    bit  after_rst = 1'b0;
    bit  prev_was_rst = 1'b0;
    bit  prev_rd = 1'b0;
    logic [13:0] prev_addr = '0;
    logic exp_ack = 1'b0;
    logic exp_busy = 1'b0;
    logic [13:0] last_addr = '0;
    logic [7:0]  last_dout = '0;
    logic [7:0]  last_crd = '0;

    // reference model: CPU slot as pending/in-flight, plus render grants counted while it waits
    int          m_state = 0;
    int          m_wait = 0;
    int          m_done_at = 0;
    bit          m_rnw = 1'b0;
    logic [13:0] m_addr = '0;
    logic [7:0]  m_wdata = '0;

    function automatic logic [7:0] mem_byte(input logic [13:0] a);
        return a[7:0] ^ {a[13:8], 2'b01} ^ 8'h5A;
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit rr, input logic [13:0] ra, input bit cr,
                        input bit crnw, input logic [13:0] ca, input logic [7:0] cw);
        bit gr;
        bit gc;
        @(posedge clk);
        #1;
        cyc++;
        data_in = prev_rd ? mem_byte(prev_addr) : 8'($urandom);
        prev_rd = (read_request === 1'b1);
        prev_addr = addr;
        after_rst = prev_was_rst;
        if (prev_was_rst) begin
            last_addr = '0;
            last_dout = '0;
            last_crd  = '0;
        end
        rst = r; rnd_req = rr; rnd_addr = ra;
        cpu_req = cr; cpu_r_nw = crnw; cpu_addr = ca; cpu_wdata = cw;

        exp_busy = (m_state != 0);
        gr = rr && (m_wait < LIMIT);
        exp_ack = gr;
        prev_was_rst = r;
        if (r) begin
            while (q_rd.size() > 0 && q_rd[$].due > cyc) void'(q_rd.pop_back());
            while (q_wr.size() > 0 && q_wr[$].due > cyc) void'(q_wr.pop_back());
            while (q_rv.size() > 0 && q_rv[$].due > cyc) void'(q_rv.pop_back());
            while (q_cd.size() > 0 && q_cd[$].due > cyc) void'(q_cd.pop_back());
            m_state = 0;
            m_wait  = 0;
        end else begin
            gc = !gr && (m_state == 1);
            if (gr) begin
                q_rd.push_back('{cyc + 1, ra, 8'h00, 1'b1});
                q_rv.push_back('{cyc + 3, ra, mem_byte(ra), 1'b1});
            end
            if (gc) begin
                if (m_rnw) begin
                    q_rd.push_back('{cyc + 1, m_addr, 8'h00, 1'b1});
                    q_cd.push_back('{cyc + 3, m_addr, mem_byte(m_addr), 1'b1});
                end else begin
                    q_wr.push_back('{cyc + 1, m_addr, m_wdata, 1'b0});
                    q_cd.push_back('{cyc + 1, m_addr, m_wdata, 1'b0});
                end
            end
            m_wait = ((m_state == 1) && gr) ? m_wait + 1 : 0;
            case (m_state)
                0: if (cr) begin
                    m_state = 1; m_rnw = crnw; m_addr = ca; m_wdata = cw;
                end
                1: if (gc) begin
                    m_state = m_rnw ? 2 : 0;
                    m_done_at = cyc + 3;
                end
                default: if (cyc + 1 == m_done_at) m_state = 0;
            endcase
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 8'h0);
    endtask

    // monitor: compares every DUT output event against the head of its expectation queue
    always @(negedge clk) begin : mon
        exp_t e;
        if (armed) begin
            chk(rnd_ack === exp_ack, "rnd_ack", int'(rnd_ack), int'(exp_ack));
            chk(cpu_busy === exp_busy, "cpu_busy", int'(cpu_busy), int'(exp_busy));
            chk(!(read_request && write_request), "strobe_exclusive", int'(write_request), 0);
            if (after_rst) begin
                chk({read_request, write_request, rnd_rvalid, cpu_done, cpu_busy} === 5'b0,
                    "reset_strobes", int'({read_request, write_request, rnd_rvalid, cpu_done, cpu_busy}), 0);
                chk({addr, data_out, cpu_rdata, rnd_rdata} === 38'b0, "reset_data",
                    int'(addr), 0);
            end

            if (read_request === 1'b1) begin
                if (q_rd.size() == 0) chk(1'b0, "rd_unexpected", int'(addr), 0);
                else begin
                    e = q_rd.pop_front();
                    chk(e.due == cyc, "rd_time", cyc, e.due);
                    chk(addr === e.a, "rd_addr", int'(addr), int'(e.a));
                end
            end else if (q_rd.size() > 0 && q_rd[0].due <= cyc) begin
                chk(1'b0, "rd_missing", 0, int'(q_rd[0].a));
                void'(q_rd.pop_front());
            end

            if (write_request === 1'b1) begin
                if (q_wr.size() == 0) chk(1'b0, "wr_unexpected", int'(addr), 0);
                else begin
                    e = q_wr.pop_front();
                    chk(e.due == cyc, "wr_time", cyc, e.due);
                    chk(addr === e.a, "wr_addr", int'(addr), int'(e.a));
                    chk(data_out === e.d, "wr_data", int'(data_out), int'(e.d));
                end
            end else if (q_wr.size() > 0 && q_wr[0].due <= cyc) begin
                chk(1'b0, "wr_missing", 0, int'(q_wr[0].a));
                void'(q_wr.pop_front());
            end

            if (rnd_rvalid === 1'b1) begin
                if (q_rv.size() == 0) chk(1'b0, "rvalid_unexpected", int'(rnd_rdata), 0);
                else begin
                    e = q_rv.pop_front();
                    chk(e.due == cyc, "rvalid_time", cyc, e.due);
                    chk(rnd_rdata === e.d, "rnd_rdata", int'(rnd_rdata), int'(e.d));
                end
            end else if (q_rv.size() > 0 && q_rv[0].due <= cyc) begin
                chk(1'b0, "rvalid_missing", 0, int'(q_rv[0].d));
                void'(q_rv.pop_front());
            end

            if (cpu_done === 1'b1) begin
                if (q_cd.size() == 0) chk(1'b0, "done_unexpected", int'(cpu_rdata), 0);
                else begin
                    e = q_cd.pop_front();
                    chk(e.due == cyc, "done_time", cyc, e.due);
                    if (e.is_rd) begin
                        chk(cpu_rdata === e.d, "cpu_rdata", int'(cpu_rdata), int'(e.d));
                        last_crd = e.d;
                    end
                end
            end else if (q_cd.size() > 0 && q_cd[0].due <= cyc) begin
                chk(1'b0, "done_missing", 0, int'(q_cd[0].a));
                void'(q_cd.pop_front());
            end
            chk(cpu_rdata === last_crd, "cpu_rdata_hold", int'(cpu_rdata), int'(last_crd));

            if (read_request === 1'b1 || write_request === 1'b1) last_addr = addr;
            else chk(addr === last_addr, "addr_hold", int'(addr), int'(last_addr));
            if (write_request === 1'b1) last_dout = data_out;
            else chk(data_out === last_dout, "data_out_hold", int'(data_out), int'(last_dout));
        end
    end

    initial begin
        step(1'b1, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 8'h0);
        step(1'b1, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 8'h0);
        armed = 1'b1;
        idle(2);

        // four back-to-back render fetches
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 14'h2000 + 14'(i), 1'b0, 1'b0, 14'h0, 8'h0);
        idle(5);

        // single CPU write on an idle bus
        step(1'b0, 1'b0, 14'h0, 1'b1, 1'b0, 14'h3F00, 8'h0F);
        idle(4);

        // CPU read starved by continuous render traffic
        step(1'b0, 1'b1, 14'h2100, 1'b1, 1'b1, 14'h23C0, 8'h00);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 14'h2101 + 14'(i), 1'b0, 1'b0, 14'h0, 8'h0);
        idle(5);

        // second request while busy is dropped
        step(1'b0, 1'b0, 14'h0, 1'b1, 1'b0, 14'h0100, 8'hAA);
        step(1'b0, 1'b0, 14'h0, 1'b1, 1'b0, 14'h0200, 8'h55);
        idle(4);

        // request in the cpu_done cycle is accepted
        step(1'b0, 1'b0, 14'h0, 1'b1, 1'b0, 14'h0300, 8'h11);
        idle(1);
        step(1'b0, 1'b0, 14'h0, 1'b1, 1'b1, 14'h0301, 8'h00);
        idle(5);

        // reset right after a CPU read grant discards the return
        step(1'b0, 1'b0, 14'h0, 1'b1, 1'b1, 14'h0400, 8'h00);
        idle(1);
        step(1'b1, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 8'h0);
        idle(4);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(199) == 0, $urandom_range(9) < 7, 14'($urandom),
                 $urandom_range(9) < 2, 1'($urandom_range(1)), 14'($urandom), 8'($urandom));
        end
        idle(10);

        chk(q_rd.size() == 0, "rd_leftover", q_rd.size(), 0);
        chk(q_wr.size() == 0, "wr_leftover", q_wr.size(), 0);
        chk(q_rv.size() == 0, "rvalid_leftover", q_rv.size(), 0);
        chk(q_cd.size() == 0, "done_leftover", q_cd.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
